// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, instruction RAM addressing and the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = branch_target & ~32'h3;

  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    fault_d      = fault_q;

    if (stall) begin
      // ID holds branch_taken until the stall drops, so nothing is lost here.
    end else if (branch_taken) begin
      pc_d         = target_aligned;
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b0;
      fault_d      = (target_aligned > LAST_ADDR);
    end else if (flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b0;
      if (!fault_q) begin
        if (pc_plus4 > LAST_ADDR) fault_d = 1'b1;
        else                      pc_d    = pc_plus4;
      end
    end else if (fault_q) begin
      // Faulted: imem_data is never consumed, only bubbles flow to ID.
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b0;
    end else begin
      ifid_instr_d = imem_data;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      if (pc_plus4 > LAST_ADDR) fault_d = 1'b1;
      else                      pc_d    = pc_plus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q         <= PC_RESET;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;

  // Stall and fault bubbles are deliberately not counted as squashes.
  always_comb begin
    perf_fetched_d  = perf_fetched_q;
    perf_squashed_d = perf_squashed_q;
    if (!stall) begin
      if (branch_taken || flush) perf_squashed_d = perf_squashed_q + 32'd1;
      else if (!fault_q)         perf_fetched_d  = perf_fetched_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      perf_fetched_q  <= 32'h0;
      perf_squashed_q <= 32'h0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`else
  assign perf_fetched  = 32'h0;
  assign perf_squashed = 32'h0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage pipeline: owns the PC register, drives the instruction RAM address and captures the returned word into the IF/ID pipeline register.
- Handles stall hold, taken-branch redirect from ID (target from ID branch adder) and squash/flush bubbles.
- Output feeds ID: register file read selects, sign extender, branch adder.
- Instruction RAM is combinational (data valid same cycle as address).

Parameters:
- PC_RESET, 32'h00000000, PC value loaded on reset.
- IMEM_BYTES, 256, instruction RAM size in bytes; last legal fetch address is IMEM_BYTES-4.
- NOP_INSTR, 32'hE1A00000, encoding inserted as a bubble (MOV R0,R0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID contents (load-use hazard).
- branch_taken  in  1  redirect request from ID.
- branch_target  in  32  redirect byte address from ID.
- flush  in  1  squash IF/ID without redirect.
- imem_addr  out  32  address to instruction RAM; equals PC register.
- imem_data  in  32  instruction word from RAM.
- ifid_instr  out  32  registered instruction to ID.
- ifid_pc  out  32  registered address of ifid_instr.
- ifid_pc4  out  32  registered ifid_pc+4.
- ifid_valid  out  1  1 = ifid_instr is a real instruction.
- fetch_fault  out  1  PC outside instruction RAM; fetch halted.
- perf_fetched  out  32  retired-fetch counter (optional feature).
- perf_squashed  out  32  squashed-fetch counter (optional feature).

Behaviour:
- Reset (clr=0, asynchronous, overrides all):
  - pc=PC_RESET, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0.
  - ifid_valid=0, fetch_fault=0, perf counters=0.
- imem_addr = pc, combinational; pc always word-aligned.
- Per rising edge, priority order (highest first):
  1. stall=1: pc, IF/ID and fetch_fault all hold. branch_taken and flush are ignored; ID keeps branch_taken asserted until stall drops.
  2. branch_taken=1:
     - pc <= branch_target & ~32'h3.
     - IF/ID <= {NOP_INSTR, pc, pc+4} with ifid_valid=0 (wrong-path word discarded).
     - fetch_fault <= 1 if the aligned target > IMEM_BYTES-4, else 0.
  3. flush=1: pc <= pc+4 (or holds if faulted); IF/ID gets a bubble with ifid_valid=0.
  4. fetch_fault=1: pc holds; IF/ID gets a bubble each cycle.
  5. Normal: IF/ID <= {imem_data, pc, pc+4}, ifid_valid=1.
     - If pc+4 > IMEM_BYTES-4: pc holds and fetch_fault <= 1.
     - Else pc <= pc+4.
- Fault exit: only reset or a taken branch to a legal address clears fetch_fault.
- Single-cycle latency: word at pc appears on ifid_instr one edge later.
- Arithmetic: pc+4 is 32-bit unsigned with wrap; wrap is unreachable because the fault check fires first.
- imem_data is ignored while faulted, so no out-of-range RAM read is consumed.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on every edge that loads IF/ID with ifid_valid=1.
  - perf_squashed increments on every edge that inserts a bubble due to branch_taken or flush.
  - Neither counts during stall or fault bubbles.
  - Both wrap at 2^32; reset to 0.
- Not defined: both ports tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset then 4 free-running edges, RAM word at addr n = 32'h1000_0000+n -> ifid_pc steps 0,4,8,C; ifid_instr matches; ifid_valid=1 from edge 1; imem_addr=10 after edge 4.
- Assert stall for 3 edges at pc=8 -> imem_addr stays 8; ifid_instr/ifid_pc unchanged; resumes with pc=C on release.
- branch_taken with target 32'h43 at pc=10 -> next imem_addr=40; ifid_valid=0, ifid_instr=E1A00000; following edge ifid_pc=40, valid=1. Repeat with stall=1 on the same edge -> nothing changes.
- Run to pc=FC -> after fetching FC, fetch_fault=1, imem_addr holds FC, bubbles follow; branch to 20 -> fault clears, ifid_pc=20 two edges later.
- Drop clr mid-stream at pc=30 -> asynchronously, pc=0, ifid_valid=0, fault=0 before the next edge.
- With FETCH_PERF_CNT_EN: 10 normal fetches, 1 branch, 1 flush -> perf_fetched=10, perf_squashed=2. Without the macro -> both read 0.
